// File: rtl/alu_writeback_pkg.sv
// Definitions shared by the ALU and its result write-back stage:
// command codes, write-back state encoding and default widths.
package alu_writeback_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;

  typedef enum logic [3:0] {
    CMD_ADD = 4'h0,
    CMD_SUB = 4'h1,
    CMD_SHR = 4'h2,
    CMD_SHL = 4'h3,
    CMD_XOR = 4'h4,
    CMD_AND = 4'h5,
    CMD_OR  = 4'h6,
    CMD_MOV = 4'h7,
    CMD_MUL = 4'h8,
    CMD_DIV = 4'h9
  } cmd_e;

  typedef enum logic [2:0] {
    WB_IDLE  = 3'd0,
    WB_REQ   = 3'd1,
    WB_WR_LO = 3'd2,
    WB_WR_HI = 3'd3,
    WB_FIN   = 3'd4
  } wb_state_e;

  // MUL and DIV carry a meaningful high word (product high half / remainder).
  function automatic logic has_hi_word(input logic [3:0] cmd);
    return (cmd == CMD_MUL) || (cmd == CMD_DIV);
  endfunction

endpackage

// File: rtl/alu_writeback.sv
// ALU result write-back: captures the result on start, writes one or two
// words over the shared bus, then pulses done (or err on an ack time-out).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// WB_IDLE  | waiting for start, result latches hold the last capture
// WB_REQ   | bus requested, waiting for grant
// WB_WR_LO | low word on the bus, waiting for ack
// WB_WR_HI | high word at addr+1 on the bus, waiting for ack
// WB_FIN   | bus released, one-cycle done/err pulse
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        cmd_code,
  input  logic [DATA_W-1:0] dst,
  input  logic [DATA_W-1:0] dst_h,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_data,
  input  logic              bus_ack,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int                CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  wb_state_e         state_q, state_d;
  logic [DATA_W-1:0] dst_l_q, dst_l_d;
  logic [DATA_W-1:0] dsth_l_q, dsth_l_d;
  logic [ADDR_W-1:0] addr_l_q, addr_l_d;
  logic              need_hi_q, need_hi_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_data_q, bus_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_comb begin
    state_d   = state_q;
    dst_l_d   = dst_l_q;
    dsth_l_d  = dsth_l_q;
    addr_l_d  = addr_l_q;
    need_hi_d = need_hi_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      WB_IDLE: begin
        if (start) begin
          dst_l_d   = dst;
          dsth_l_d  = dst_h;
          addr_l_d  = dst_addr;
          need_hi_d = has_hi_word(cmd_code);
          state_d   = WB_REQ;
        end
      end
      WB_REQ: begin
        if (bus_gnt) begin
          cnt_d   = '0;
          state_d = WB_WR_LO;
        end
      end
      WB_WR_LO, WB_WR_HI: begin
        if (bus_ack) begin
          cnt_d = '0;
          if ((state_q == WB_WR_LO) && need_hi_q) begin
            state_d = WB_WR_HI;
          end else begin
            state_d = WB_FIN;
            done_d  = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Abort: the remaining word (if any) is deliberately not written.
          state_d = WB_FIN;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WB_FIN: begin
        state_d = WB_IDLE;
      end
      default: begin
        state_d = WB_IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the next state.
    bus_req_d  = (state_d == WB_REQ) || (state_d == WB_WR_LO) || (state_d == WB_WR_HI);
    bus_we_d   = (state_d == WB_WR_LO) || (state_d == WB_WR_HI);
    busy_d     = (state_d != WB_IDLE);
    bus_addr_d = '0;
    bus_data_d = '0;
    if (state_d == WB_WR_LO) begin
      bus_addr_d = addr_l_d;
      bus_data_d = dst_l_d;
    end else if (state_d == WB_WR_HI) begin
      bus_addr_d = addr_l_d + ADDR_W'(1);
      bus_data_d = dsth_l_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WB_IDLE;
      dst_l_q    <= '0;
      dsth_l_q   <= '0;
      addr_l_q   <= '0;
      need_hi_q  <= 1'b0;
      cnt_q      <= '0;
      bus_req_q  <= 1'b0;
      bus_we_q   <= 1'b0;
      bus_addr_q <= '0;
      bus_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dst_l_q    <= dst_l_d;
      dsth_l_q   <= dsth_l_d;
      addr_l_q   <= addr_l_d;
      need_hi_q  <= need_hi_d;
      cnt_q      <= cnt_d;
      bus_req_q  <= bus_req_d;
      bus_we_q   <= bus_we_d;
      bus_addr_q <= bus_addr_d;
      bus_data_q <= bus_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus_req  = bus_req_q;
  assign bus_we   = bus_we_q;
  assign bus_addr = bus_addr_q;
  assign bus_data = bus_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: a per-edge stimulus timeline, an expected output
// trace built from transaction descriptions, and literal write/done logs.
module tb_alu_writeback;
  import alu_writeback_pkg::*;

  localparam int N  = 96;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst, start, bus_gnt, bus_ack;
  logic [3:0]  cmd_code;
  logic [31:0] dst, dst_h, dst_addr;
  logic        bus_req, bus_we, busy, done, err;
  logic [31:0] bus_addr, bus_data;

  alu_writeback #(.DATA_W(32), .ADDR_W(32), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd_code(cmd_code),
    .dst(dst), .dst_h(dst_h), .dst_addr(dst_addr),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_ack(bus_ack),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Stimulus for edge k and expected outputs just after edge k.
  bit          rst_a [N], start_a [N], gnt_a [N], ack_a [N];
  logic [3:0]  cmd_a [N];
  logic [31:0] dst_a [N], dsth_a [N], addr_a [N];
  logic [68:0] exp_v [N];

  int n_cmp = 0;
  int n_bad = 0;
  int last_edge = -1;

  int          wr_edge[$];
  logic [31:0] wr_addr[$], wr_data[$];
  int          done_edge[$], err_edge[$];

  function automatic logic [68:0] ov(input bit req, we, bsy, dn, er,
                                     input logic [31:0] a, d);
    return {req, we, bsy, dn, er, a, d};
  endfunction

  // Expected trace of one write-back: s = edge sampling start, g = edges with
  // grant low, lat0/lat1 = edges with ack low per word. Returns the FIN edge.
  task automatic plan(input int s, input logic [3:0] cmd,
                      input logic [31:0] d, dh, a,
                      input int g, lat0, lat1, output int f);
    int  k, n, lat;
    bit  two, aborted;
    logic [31:0] wa, wd;
    start_a[s] = 1; cmd_a[s] = cmd; dst_a[s] = d; dsth_a[s] = dh; addr_a[s] = a;
    ack_a[s] = 1;
    two = (cmd == CMD_MUL) || (cmd == CMD_DIV);
    for (int i = 0; i <= g; i++) exp_v[s+i] = ov(1, 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= g; i++) begin gnt_a[s+i] = 0; ack_a[s+i] = 1; end
    gnt_a[s+g+1] = 1;
    k = s + g + 1;
    aborted = 0;
    for (int w = 0; w < (two ? 2 : 1); w++) begin
      wa  = (w == 0) ? a : a + 32'd1;
      wd  = (w == 0) ? d : dh;
      lat = (w == 0) ? lat0 : lat1;
      n   = (lat < TO) ? lat + 1 : TO;
      for (int i = 0; i < n; i++) exp_v[k+i] = ov(1, 1, 1, 0, 0, wa, wd);
      for (int i = 1; i <= ((lat < TO) ? lat : TO); i++) ack_a[k+i] = 0;
      if (lat >= TO) begin
        aborted = 1;
        k = k + TO;
        break;
      end
      ack_a[k+lat+1] = 1;
      k = k + lat + 1;
    end
    f = k;
    exp_v[f] = aborted ? ov(0, 0, 1, 0, 1, 0, 0) : ov(0, 0, 1, 1, 0, 0, 0);
    ack_a[f+1] = 1;
  endtask

  task automatic reset_at(input int r, input int e);
    rst_a[r] = 1;
    for (int i = r; i <= e; i++) exp_v[i] = '0;
  endtask

  task automatic busy_start(input int k, input logic [3:0] cmd,
                            input logic [31:0] d, dh, a);
    start_a[k] = 1; cmd_a[k] = cmd; dst_a[k] = d; dsth_a[k] = dh; addr_a[k] = a;
  endtask

  task automatic chk(input string name, input logic [63:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (bus_we && bus_ack && !rst) begin
      wr_edge.push_back(last_edge + 1);
      wr_addr.push_back(bus_addr);
      wr_data.push_back(bus_data);
    end
    if (done) done_edge.push_back(last_edge);
    if (err)  err_edge.push_back(last_edge);
    last_edge <= last_edge + 1;
  end

  always @(negedge clk) begin
    logic [68:0] act;
    if (last_edge >= 0 && last_edge < N) begin
      act = {bus_req, bus_we, busy, done, err, bus_addr, bus_data};
      n_cmp++;
      if (act !== exp_v[last_edge]) begin
        n_bad++;
        $display("FAIL trace@edge%0d: got req=%b we=%b busy=%b done=%b err=%b addr=%h data=%h expected req=%b we=%b busy=%b done=%b err=%b addr=%h data=%h",
                 last_edge, act[68], act[67], act[66], act[65], act[64], act[63:32], act[31:0],
                 exp_v[last_edge][68], exp_v[last_edge][67], exp_v[last_edge][66],
                 exp_v[last_edge][65], exp_v[last_edge][64],
                 exp_v[last_edge][63:32], exp_v[last_edge][31:0]);
      end
    end
  end

  initial begin
    int f;
    int exp_we[10];
    logic [31:0] exp_wa[10], exp_wd[10];
    int exp_done[6];

    for (int i = 0; i < N; i++) begin
      rst_a[i] = 0; start_a[i] = 0; gnt_a[i] = 0; ack_a[i] = 0;
      cmd_a[i] = 4'($urandom_range(0, 15));
      dst_a[i] = $urandom; dsth_a[i] = $urandom; addr_a[i] = $urandom;
      exp_v[i] = '0;
    end
    for (int i = 0; i <= 2; i++) rst_a[i] = 1;

    plan(5, CMD_ADD, 32'h0000_0005, 32'h0000_DEAD, 32'h0000_0100, 0, 0, 0, f);
    busy_start(8, CMD_MUL, 32'h0000_0999, 32'h0000_0888, 32'h0000_0300);
    plan(9, CMD_MUL, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0200, 0, 0, 0, f);
    plan(15, CMD_DIV, 32'h0000_0007, 32'h0000_0003, 32'hFFFF_FFFF, 0, 1, 2, f);
    busy_start(19, CMD_DIV, 32'h5555_5555, 32'h6666_6666, 32'h0000_0A00);
    plan(24, CMD_SUB, 32'h1234_5678, 32'h0000_0001, 32'h0000_0400, 3, 2, 0, f);
    plan(34, CMD_XOR, 32'hA5A5_A5A5, 32'h0, 32'h0000_0500, 0, 100, 0, f);
    plan(52, CMD_MUL, 32'h0000_BEEF, 32'hCAFE_0000, 32'h0000_0600, 0, TO - 1, 0, f);
    plan(72, CMD_MUL, 32'h1111_1111, 32'h2222_2222, 32'h0000_0700, 0, 0, 3, f);
    busy_start(74, CMD_ADD, 32'h3333_3333, 32'h4444_4444, 32'h0000_0800);
    reset_at(76, f);
    plan(81, CMD_AND, 32'h0F0F_0F0F, 32'h0, 32'h0000_0900, 1, 0, 0, f);

    for (int k = 0; k < N; k++) begin
      rst = rst_a[k]; start = start_a[k]; bus_gnt = gnt_a[k]; bus_ack = ack_a[k];
      cmd_code = cmd_a[k]; dst = dst_a[k]; dst_h = dsth_a[k]; dst_addr = addr_a[k];
      @(posedge clk);
      @(negedge clk);
    end

    // Hand-computed write log, done edges and the single time-out edge.
    exp_we = '{7, 11, 12, 18, 21, 31, 68, 69, 74, 84};
    exp_wa = '{32'h100, 32'h200, 32'h201, 32'hFFFF_FFFF, 32'h0,
               32'h400, 32'h600, 32'h601, 32'h700, 32'h900};
    exp_wd = '{32'h5, 32'hFFFF_FFFE, 32'h1, 32'h7, 32'h3,
               32'h1234_5678, 32'h0000_BEEF, 32'hCAFE_0000, 32'h1111_1111, 32'h0F0F_0F0F};
    exp_done = '{7, 12, 21, 31, 69, 84};

    chk("write_count", 64'(wr_edge.size()), 64'd10);
    for (int i = 0; i < 10 && i < wr_edge.size(); i++) begin
      chk($sformatf("write%0d_edge", i), 64'(wr_edge[i]), 64'(exp_we[i]));
      chk($sformatf("write%0d_addr", i), 64'(wr_addr[i]), 64'(exp_wa[i]));
      chk($sformatf("write%0d_data", i), 64'(wr_data[i]), 64'(exp_wd[i]));
    end
    chk("done_count", 64'(done_edge.size()), 64'd6);
    for (int i = 0; i < 6 && i < done_edge.size(); i++)
      chk($sformatf("done%0d_edge", i), 64'(done_edge[i]), 64'(exp_done[i]));
    chk("err_count", 64'(err_edge.size()), 64'd1);
    if (err_edge.size() > 0) chk("err_edge", 64'(err_edge[0]), 64'd50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Result write-back stage directly downstream of the ALU. On the ALU's completion strobe it captures `dst` and `dst_h`, arbitrates for the shared memory bus, and writes the low result word to the destination address. For MUL and DIV, which produce two-word results, it also writes the high word (product high half or remainder) to the next address. It then reports completion, or a bus time-out, to the sequencer.

## Interface
Parameters:
- `DATA_W`, 32, data word width (matches ALU `dst`/`dst_h`)
- `ADDR_W`, 32, bus address width
- `ACK_TIMEOUT`, 15, maximum cycles to wait for `bus_ack` per word before aborting; must be ≥ 1

Ports:
- `clk`  in  1  single clock, all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle strobe: ALU result valid (ALU `next_state` asserted in ALU_BEGIN)
- `cmd_code`  in  4  command[31:28] of the executing instruction
- `dst`  in  DATA_W  ALU low result word
- `dst_h`  in  DATA_W  ALU high result word
- `dst_addr`  in  ADDR_W  destination address from decoder
- `bus_req`  out  1  bus request, held from request until release
- `bus_gnt`  in  1  bus grant from arbiter
- `bus_we`  out  1  write strobe, held until acknowledged
- `bus_addr`  out  ADDR_W  write address
- `bus_data`  out  DATA_W  write data
- `bus_ack`  in  1  write accepted by memory
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse: all writes completed
- `err`  out  1  one-cycle pulse: write aborted on ack time-out

## Operation
- States: IDLE, REQ, WR_LO, WR_HI, FIN.
- **IDLE**
  - On `start`: latch `dst`, `dst_h` and `dst_addr`.
  - Latch `need_hi = (cmd_code == CMD_MUL) || (cmd_code == CMD_DIV)`.
  - Go to REQ.
- **REQ**
  - `bus_req=1`.
  - On `bus_gnt` go to WR_LO and clear the time-out counter.
- **WR_LO**
  - `bus_req=1`, `bus_we=1`, `bus_addr=addr_l`, `bus_data=dst_l`.
  - On `bus_ack`: go to WR_HI if `need_hi`, otherwise go to FIN.
- **WR_HI**
  - `bus_req=1`, `bus_we=1`, `bus_addr=addr_l+1` (modulo 2^ADDR_W, so all-ones wraps to 0), `bus_data=dsth_l`.
  - On `bus_ack` go to FIN.
- **FIN**
  - `done=1` for exactly one cycle (or `err=1` instead if the block arrived here through the abort path).
  - Drop `bus_req`, then go to IDLE.
- **Ack time-out:** in WR_LO/WR_HI, a counter increments each cycle without `bus_ack`. When it reaches ACK_TIMEOUT without an ack, the block goes to FIN with `err=1`, `done=0`. It does not write the remaining word.
- **Bus hold:** after the grant, the bus is held through both words. `bus_gnt` is sampled only in REQ; a dropped grant in WR_* is ignored.
- **Other commands:** ADD/SUB/SHR/SHL/XOR/AND/OR/MOV perform a low-word write only. The ADD/SUB carry in `dst_h` is not written.
- **`start` while busy:** ignored, with no state or latch change.
- **Output contents:** outputs are registered. `bus_addr`/`bus_data` are 0 whenever `bus_we=0`.

## Timing
- **Reset:** every output is 0 (`bus_req`, `bus_we`, `bus_addr`, `bus_data`, `busy`, `done`, `err`), the state is IDLE, and the latches and counter are cleared.
- **Reset mid-transfer:** all outputs return to 0 on that edge and the bus is released in that same cycle. No `done` or `err` is issued.
- **Best-case latency,** with `bus_gnt` and `bus_ack` high whenever sampled, counting from the edge that samples `start`:
  - single word: REQ +1, WR_LO +2, `done` +3;
  - two words: WR_HI +3, `done` +4.
- **Ack sampling:** `bus_ack` is sampled on the same edge that the write strobe is presented. An ack in the first WR cycle completes that word in one cycle.
- **Back-to-back starts:** the earliest new `start` is accepted on the cycle after FIN (IDLE). A `start` coincident with the `done` pulse is ignored.
- **`bus_ack` outside WR_*:** ignored.

## Structure
- Shared package (common with the ALU):
  - CMD_* 4-bit command codes;
  - writeback state encoding (3-bit);
  - DATA_W/ADDR_W defaults.
- Single module, no sub-module.
- The time-out counter is `$clog2(ACK_TIMEOUT+1)` bits, inline.

## Test plan
- **ADD single word:** `start`, cmd=ADD, dst=0x00000005, dst_addr=0x100; gnt and ack always high → one write (0x100, 0x5); `done` at +3; `dst_h` never driven.
- **MUL two words:** dst=0xFFFFFFFE, dst_h=0x1, dst_addr=0x200 → writes (0x200, 0xFFFFFFFE) then (0x201, 0x1); `done` at +4; `bus_req` high continuously from +1 to +3.
- **Address wrap:** DIV, dst_addr=0xFFFFFFFF → second write to 0x00000000.
- **Delayed handshake:** `bus_gnt` held low 3 cycles, `bus_ack` low 2 cycles on the low word → `bus_we`/`bus_addr`/`bus_data` stable throughout; `done` at +8 for a one-word command.
- **Time-out:** `bus_ack` never asserted, ACK_TIMEOUT=15 → `err` pulse (with `done=0`), then `bus_req` drops, state IDLE; a following MUL completes normally.
- **Reset and ignored start:** `rst` asserted in WR_HI → all outputs 0 on the next edge, no `done`. A `start` issued while `busy` → no effect on the latched data or the write sequence.
